lift_n: RTL and testbench
=========================

Name: lift_n

Overview:
- Parametrised elevator controller; next generation of the five-floor lift, generalised to NUM_FLOORS floors.
- Adds latched pending requests, SCAN direction policy, per-floor travel time, a timed door with hold, and exported status.
- Sits between the floor call buttons (one-cycle pulses) and the floor indicator and door drive.

Parameters:
- NUM_FLOORS, 8, number of floors (>=2); floor 0 is the lowest.
- FLOOR_W, $clog2(NUM_FLOORS), width of the floor index.
- TRAVEL_CYCLES, 4, cycles to move one floor (>=1).
- DOOR_CYCLES, 3, cycles the door stays open (>=1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  NUM_FLOORS  call request per floor; a single-cycle pulse suffices.
- door_hold  input  1  while high in DOOR, the door timer is held at reload.
- floor  output  FLOOR_W  current floor.
- dir  output  1  0=UP, 1=DOWN.
- moving  output  1  high in MOVE.
- door_open  output  1  high in DOOR.
- pending  output  NUM_FLOORS  latched, unserved requests.

Behaviour:
- Reset (rst low, immediate, mid-operation included): state IDLE, floor=0, dir=UP, pending=0, timer=0, moving=0, door_open=0.
- Latch: pending |= req on every edge, except where clearing below wins.
- States: IDLE, MOVE, DOOR. above = any pending bit > floor; below = any pending bit < floor.
- IDLE:
  - pending[floor] set -> DOOR, clear that bit, timer=DOOR_CYCLES-1.
  - Else dir==UP and above -> MOVE, UP.
  - Else below -> MOVE, DOWN.
  - Else above -> MOVE, UP.
  - Else stay IDLE.
  - Entering MOVE loads timer=TRAVEL_CYCLES-1.
- MOVE:
  - timer!=0 -> decrement.
  - timer==0 -> floor +1 (UP) or -1 (DOWN).
  - If pending[new floor] -> DOOR, clear that bit (clear beats a same-edge req), timer=DOOR_CYCLES-1.
  - Else stay MOVE, reload TRAVEL_CYCLES-1.
  - Floor never leaves 0..NUM_FLOORS-1: motion only occurs toward a pending bit.
- DOOR:
  - req[floor] or door_hold high -> timer reloads DOOR_CYCLES-1; req[floor] is absorbed, not latched.
  - Else timer!=0 -> decrement.
  - Else exit on the same priority as IDLE, continuing in the current dir first: ahead -> MOVE same dir; behind -> flip dir, MOVE; none -> IDLE.
- Latency: a req pulse sampled at edge k reaches MOVE at edge k+1. Floor steps at k+1+TRAVEL_CYCLES, then every TRAVEL_CYCLES edges. Door stays open DOOR_CYCLES cycles absent hold or re-request.
- Requests for the current floor while in MOVE are latched and served on a later visit.
- dir changes only when leaving IDLE or DOOR.
- Outputs are registered or decoded from state only; no combinational path from req to outputs.

Decomposition:
- Package lift_pkg:
  - state enum {IDLE, MOVE, DOOR}.
  - dir enum {UP=0, DOWN=1}.
- Sub-module lift_req_scan: combinational; takes pending and floor, returns above, below and here. Uses generate-built masks, so it scales with NUM_FLOORS.
- Top lift_n holds the FSM, timer, floor, dir and pending registers.

Test Plan:
- Reset from floor 3 mid-MOVE with rst low -> immediately floor=0, dir=UP, pending=0, moving=0, door_open=0.
- Defaults, floor 0, req[2] pulse at edge 0 -> MOVE at edge 1, floor=1 at edge 5, floor=2 with door_open at edge 9, IDLE at edge 12, pending=0.
- At floor 4 going UP with pending {6,1} -> serves 6 first. Then dir=DOWN, floor 6->1 taking 5*TRAVEL_CYCLES cycles, door opens at 1.
- At floor 2 in DOOR, req[2] pulsed every 2 cycles -> door stays open. Door closes 3 cycles after the last pulse; pending[2] never set.
- door_hold high for 10 cycles in DOOR -> door_open high for 10+3 cycles; the queued req[5] is served afterwards.
- NUM_FLOORS=16: req[15] and req[0] at the same edge from floor 7, dir=UP -> reaches 15 first, then 0; floor never exceeds 15 or wraps.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types for the lift_n elevator controller: FSM state and travel direction.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lift_req_scan.sv
// Combinational scan of latched requests relative to the current floor.
// Masks are built per floor so the logic scales with NUM_FLOORS.
module lift_req_scan #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  above,
    output logic                  below,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] above_mask_s;
    logic [NUM_FLOORS-1:0] below_mask_s;
    logic [NUM_FLOORS-1:0] here_mask_s;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_mask
        assign above_mask_s[i] = (FLOOR_W'(i) >  floor);
        assign below_mask_s[i] = (FLOOR_W'(i) <  floor);
        assign here_mask_s[i]  = (FLOOR_W'(i) == floor);
    end

    assign above = |(pending & above_mask_s);
    assign below = |(pending & below_mask_s);
    assign here  = |(pending & here_mask_s);

endmodule

// File: rtl/lift_n.sv
// NUM_FLOORS elevator controller: latched calls, SCAN direction policy,
// per-floor travel timer and a door timer that can be held or re-armed.
module lift_n
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TMAX    = max2(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TIMER_W-1:0]    TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    T_ZERO      = TIMER_W'(0);
    localparam logic [TIMER_W-1:0]    T_ONE       = TIMER_W'(1);
    localparam logic [FLOOR_W-1:0]    F_ZERO      = FLOOR_W'(0);
    localparam logic [FLOOR_W-1:0]    F_ONE       = FLOOR_W'(1);
    localparam logic [NUM_FLOORS-1:0] P_ZERO      = NUM_FLOORS'(0);
    localparam logic [NUM_FLOORS-1:0] P_ONE       = NUM_FLOORS'(1);

    state_e                  state_r;
    state_e                  state_nx_s;
    logic [FLOOR_W-1:0]      floor_r;
    logic [FLOOR_W-1:0]      floor_nx_s;
    logic [FLOOR_W-1:0]      step_floor_s;
    dir_e                    dir_r;
    dir_e                    dir_nx_s;
    logic [TIMER_W-1:0]      timer_r;
    logic [TIMER_W-1:0]      timer_nx_s;
    logic [NUM_FLOORS-1:0]   pending_r;
    logic [NUM_FLOORS-1:0]   pending_nx_s;
    logic [NUM_FLOORS-1:0]   clear_s;
    logic                    above_s;
    logic                    below_s;
    logic                    here_s;
    logic                    ahead_s;
    logic                    behind_s;
    logic                    arrive_s;
    logic                    req_here_s;
    logic                    moving_s;
    logic                    door_open_s;

    lift_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending (pending_r),
        .floor   (floor_r),
        .above   (above_s),
        .below   (below_s),
        .here    (here_s)
    );

    // Motion only happens toward a pending bit, so the step never leaves the shaft.
    assign step_floor_s = (dir_r == UP) ? (floor_r + F_ONE) : (floor_r - F_ONE);
    assign arrive_s     = |(pending_r & (P_ONE << step_floor_s));
    assign req_here_s   = |(req & (P_ONE << floor_r));
    assign ahead_s      = (dir_r == UP) ? above_s : below_s;
    assign behind_s     = (dir_r == UP) ? below_s : above_s;

    // Clearing a served floor wins over a request arriving on the same edge.
    assign pending_nx_s = (pending_r | req) & ~clear_s;

    // State, position, direction, timer and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            floor_r   <= F_ZERO;
            dir_r     <= UP;
            timer_r   <= T_ZERO;
            pending_r <= P_ZERO;
        end else begin
            state_r   <= state_nx_s;
            floor_r   <= floor_nx_s;
            dir_r     <= dir_nx_s;
            timer_r   <= timer_nx_s;
            pending_r <= pending_nx_s;
        end
    end

    // Next-state, timer, floor and direction decisions.
    always_comb begin
        state_nx_s = state_r;
        floor_nx_s = floor_r;
        dir_nx_s   = dir_r;
        timer_nx_s = timer_r;
        clear_s    = P_ZERO;
        case (state_r)
            IDLE: begin
                if (here_s) begin
                    state_nx_s = DOOR;
                    clear_s    = P_ONE << floor_r;
                    timer_nx_s = DOOR_LOAD;
                end else if ((dir_r == UP) && above_s) begin
                    state_nx_s = MOVE;
                    dir_nx_s   = UP;
                    timer_nx_s = TRAVEL_LOAD;
                end else if (below_s) begin
                    state_nx_s = MOVE;
                    dir_nx_s   = DOWN;
                    timer_nx_s = TRAVEL_LOAD;
                end else if (above_s) begin
                    state_nx_s = MOVE;
                    dir_nx_s   = UP;
                    timer_nx_s = TRAVEL_LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MOVE: begin
                if (timer_r != T_ZERO) begin
                    timer_nx_s = timer_r - T_ONE;
                end else begin
                    floor_nx_s = step_floor_s;
                    if (arrive_s) begin
                        state_nx_s = DOOR;
                        clear_s    = P_ONE << step_floor_s;
                        timer_nx_s = DOOR_LOAD;
                    end else begin
                        timer_nx_s = TRAVEL_LOAD;
                    end
                end
            end
            DOOR: begin
                // A call for the open floor is absorbed rather than latched.
                clear_s = P_ONE << floor_r;
                if (req_here_s || door_hold) begin
                    timer_nx_s = DOOR_LOAD;
                end else if (timer_r != T_ZERO) begin
                    timer_nx_s = timer_r - T_ONE;
                end else if (ahead_s) begin
                    state_nx_s = MOVE;
                    timer_nx_s = TRAVEL_LOAD;
                end else if (behind_s) begin
                    state_nx_s = MOVE;
                    dir_nx_s   = (dir_r == UP) ? DOWN : UP;
                    timer_nx_s = TRAVEL_LOAD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Status decoded from the state register only.
    always_comb begin
        moving_s    = 1'b0;
        door_open_s = 1'b0;
        case (state_r)
            MOVE:    moving_s    = 1'b1;
            DOOR:    door_open_s = 1'b1;
            default: begin
                moving_s    = 1'b0;
                door_open_s = 1'b0;
            end
        endcase
    end

    assign floor     = floor_r;
    assign dir       = dir_r;
    assign moving    = moving_s;
    assign door_open = door_open_s;
    assign pending   = pending_r;

endmodule

// File: tb/tb_lift_n.sv
// Bench for lift_n: an 8-floor and a 16-floor instance checked every cycle
// against a behavioural model, plus directed latency and boundary scenarios.
module tb_lift_n;

    localparam int TRV    = 4;
    localparam int DRC    = 3;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    typedef struct {
        int          st;
        int          fl;
        int          dr;
        int          tm;
        logic [15:0] pd;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req8;
    logic        h8;
    logic [2:0]  fl8;
    logic        d8, mv8, do8;
    logic [7:0]  pd8;
    logic [15:0] req16;
    logic        h16;
    logic [3:0]  fl16;
    logic        d16, mv16, do16;
    logic [15:0] pd16;
    logic [31:0] obs8, obs16;

    int   n_run  = 0;
    int   n_fail = 0;
    mdl_t m8, m16;

    always #5 clk = ~clk;

    lift_n #(.NUM_FLOORS(8), .TRAVEL_CYCLES(TRV), .DOOR_CYCLES(DRC)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .door_hold(h8), .floor(fl8),
        .dir(d8), .moving(mv8), .door_open(do8), .pending(pd8));

    lift_n #(.NUM_FLOORS(16), .TRAVEL_CYCLES(TRV), .DOOR_CYCLES(DRC)) dut16 (
        .clk(clk), .rst(rst), .req(req16), .door_hold(h16), .floor(fl16),
        .dir(d16), .moving(mv16), .door_open(do16), .pending(pd16));

    assign obs8  = {9'd0, 8'd0, pd8, 1'b0, fl8, d8, mv8, do8};
    assign obs16 = {9'd0, pd16, fl16, d16, mv16, do16};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = M_IDLE; m.fl = 0; m.dr = 0; m.tm = 0; m.pd = 16'd0;
        return m;
    endfunction

    function automatic logic [31:0] mpk(input mdl_t m);
        return {9'd0, m.pd, 4'(m.fl), 1'(m.dr), (m.st == M_MOVE), (m.st == M_DOOR)};
    endfunction

    // One clock edge of the lift as described by its rules, for nf floors.
    function automatic mdl_t mstep(input mdl_t s, input logic [15:0] rq, input logic hd, input int nf);
        mdl_t n;
        logic above, below, ahead, behind;
        n = s;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < nf; i++) begin
            if (s.pd[i] && i > s.fl) above = 1'b1;
            if (s.pd[i] && i < s.fl) below = 1'b1;
        end
        ahead  = (s.dr == 0) ? above : below;
        behind = (s.dr == 0) ? below : above;
        n.pd = s.pd | rq;
        if (s.st == M_IDLE) begin
            if (s.pd[s.fl]) begin
                n.st = M_DOOR; n.pd[s.fl] = 1'b0; n.tm = DRC - 1;
            end else if (ahead || behind) begin
                n.st = M_MOVE; n.tm = TRV - 1;
                n.dr = ((s.dr == 0 && above) || !below) ? 0 : 1;
            end
        end else if (s.st == M_MOVE) begin
            if (s.tm > 0) begin
                n.tm = s.tm - 1;
            end else begin
                n.fl = (s.dr == 0) ? s.fl + 1 : s.fl - 1;
                if (s.pd[n.fl]) begin
                    n.st = M_DOOR; n.pd[n.fl] = 1'b0; n.tm = DRC - 1;
                end else begin
                    n.tm = TRV - 1;
                end
            end
        end else begin
            n.pd[s.fl] = 1'b0;
            if (rq[s.fl] || hd) n.tm = DRC - 1;
            else if (s.tm > 0) n.tm = s.tm - 1;
            else if (ahead) begin n.st = M_MOVE; n.tm = TRV - 1; end
            else if (behind) begin n.st = M_MOVE; n.tm = TRV - 1; n.dr = 1 - s.dr; end
            else n.st = M_IDLE;
        end
        for (int i = 0; i < 16; i++) if (i >= nf) n.pd[i] = 1'b0;
        return n;
    endfunction

    task automatic tick(input logic [7:0] a, input logic [15:0] b, input logic ha, input logic hb);
        req8 = a; req16 = b; h8 = ha; h16 = hb;
        @(posedge clk);
        m8  = mstep(m8, {8'd0, a}, ha, 8);
        m16 = mstep(m16, b, hb, 16);
        @(negedge clk);
        check_eq("st8", obs8, mpk(m8));
        check_eq("st16", obs16, mpk(m16));
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        m8  = mreset();
        m16 = mreset();
        check_eq("rst8", obs8, mpk(m8));
        check_eq("rst16", obs16, mpk(m16));
        req8 = 8'd0; req16 = 16'd0; h8 = 1'b0; h16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int          nd, t, ddir, cnt, n15, n0, hcnt;
        int          df[2], dt[2];
        logic        prev, hr;
        logic [7:0]  a;
        logic [15:0] b;

        rst = 1'b0; req8 = 8'd0; req16 = 16'd0; h8 = 1'b0; h16 = 1'b0;
        m8 = mreset(); m16 = mreset();
        @(negedge clk);
        check_eq("rst_init8", obs8, mpk(m8));
        check_eq("rst_init16", obs16, mpk(m16));
        rst = 1'b1;

        // req[2] from floor 0: MOVE at edge 1, floor 1 at 5, door at 2 on 9, IDLE at 12.
        tick(8'h04, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            tick(8'h00, 16'h0000, 1'b0, 1'b0);
            if (i == 1)  check_eq("a_move", 32'(mv8), 32'd1);
            if (i == 4)  check_eq("a_fl0", 32'(fl8), 32'd0);
            if (i == 5)  check_eq("a_fl1", 32'(fl8), 32'd1);
            if (i == 9)  check_eq("a_door2", {28'd0, fl8, do8}, {28'd0, 3'd2, 1'b1});
            if (i == 11) check_eq("a_open", 32'(do8), 32'd1);
            if (i == 12) check_eq("a_idle", {22'd0, mv8, do8, pd8}, 32'd0);
        end

        // Going up past floor 4 with 6 and 1 pending: 6 first, then down to 1.
        tick(8'h40, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 60 && m8.fl != 4; i++) tick(8'h00, 16'h0000, 1'b0, 1'b0);
        tick(8'h02, 16'h0000, 1'b0, 1'b0);
        nd = 0; t = 0; ddir = -1; df[0] = -1; df[1] = -1; dt[0] = 0; dt[1] = 0;
        prev = do8;
        for (int i = 0; i < 200 && nd < 2; i++) begin
            tick(8'h00, 16'h0000, 1'b0, 1'b0);
            t++;
            if (do8 && !prev) begin
                df[nd] = int'(fl8);
                dt[nd] = t;
                if (nd == 1) ddir = int'(d8);
                nd++;
            end
            prev = do8;
        end
        check_eq("b_doors", 32'(nd), 32'd2);
        check_eq("b_first", 32'(df[0]), 32'd6);
        check_eq("b_second", 32'(df[1]), 32'd1);
        check_eq("b_gap", 32'(dt[1] - dt[0]), 32'(DRC + 5 * TRV));
        check_eq("b_dir", 32'(ddir), 32'd1);

        // Re-request of the open floor every 2 cycles keeps the door open.
        for (int p = 0; p < 4; p++) begin
            tick(8'h02, 16'h0000, 1'b0, 1'b0);
            check_eq("c_open", 32'(do8), 32'd1);
            check_eq("c_pend", 32'(pd8[1]), 32'd0);
            tick(8'h00, 16'h0000, 1'b0, 1'b0);
            check_eq("c_open", 32'(do8), 32'd1);
        end
        tick(8'h00, 16'h0000, 1'b0, 1'b0);
        check_eq("c_open", 32'(do8), 32'd1);
        tick(8'h00, 16'h0000, 1'b0, 1'b0);
        check_eq("c_close", 32'(do8), 32'd0);

        // door_hold for 10 cycles at floor 3 with req[5] queued meanwhile.
        tick(8'h08, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 60 && m8.st != M_DOOR; i++) tick(8'h00, 16'h0000, 1'b0, 1'b0);
        cnt = do8 ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            tick((i == 2) ? 8'h20 : 8'h00, 16'h0000, 1'b1, 1'b0);
            if (do8) cnt++;
        end
        for (int i = 0; i < 20 && do8; i++) begin
            tick(8'h00, 16'h0000, 1'b0, 1'b0);
            if (do8) cnt++;
        end
        check_eq("d_len", 32'(cnt), 32'(10 + DRC));
        check_eq("d_pend5", 32'(pd8[5]), 32'd1);

        // Asynchronous reset while moving away from floor 3.
        check_eq("r_pre", {28'd0, fl8, mv8}, {28'd0, 3'd3, 1'b1});
        do_reset();

        // 16 floors: park at 7 going up, then call 15 and 0 together.
        tick(8'h00, 16'h0080, 1'b0, 1'b0);
        for (int i = 0; i < 80 && !(m16.st == M_IDLE && m16.fl == 7); i++)
            tick(8'h00, 16'h0000, 1'b0, 1'b0);
        tick(8'h00, 16'h8001, 1'b0, 1'b0);
        n15 = -1; n0 = -1;
        for (int n = 1; n <= 120; n++) begin
            tick(8'h00, 16'h0000, 1'b0, 1'b0);
            if (fl16 == 4'd15 && n15 < 0) n15 = n;
            if (fl16 == 4'd0 && n15 >= 0 && n0 < 0) n0 = n;
        end
        check_eq("e_f15", 32'(n15), 32'(8 * TRV + 1));
        check_eq("e_f0", 32'(n0), 32'(8 * TRV + 1 + DRC + 15 * TRV));

        // Random calls and hold bursts on both instances.
        hcnt = 0;
        for (int i = 0; i < 2000; i++) begin
            a = ($urandom_range(0, 5) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
            b = ($urandom_range(0, 5) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
            if (hcnt == 0 && $urandom_range(0, 40) == 0) hcnt = $urandom_range(1, 8);
            hr = (hcnt > 0);
            if (hcnt > 0) hcnt--;
            tick(a, b, hr, ($urandom_range(0, 30) == 0));
            if (i == 1000) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
